// File: rtl/load_writeback_unit.sv
// load_writeback_unit
//   Executes MIPS loads (LB/LBU/LH/LHU/LW/LWL/LWR) on behalf of the execute
//   stage. Each load issues a single word read on an Avalon-style port. The
//   addressed byte, half or word is then extracted (little-endian) and written
//   back through the register file write port. LWL/LWR merge the loaded bytes
//   with the old rt value, which is captured when the load starts.
//
//   State | meaning
//   IDLE  | waiting for start
//   REQ   | mem_read held until mem_waitrequest drops or the timeout expires
//   WRITE | one cycle: done (and reg_write_enable unless suppressed or error)
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   clk_enable        0 freezes all state and outputs
//   start, load_type, addr, rt_index, rt_old   load request from execute
//   mem_*             word read port (byteenable tied to all ones)
//   write_reg_rd, reg_write_data, reg_write_enable   register file write port
//   busy, done, error status
module load_writeback_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit SUPPRESS_R0    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [4:0]  rt_index,
    input  logic [31:0] rt_old,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [4:0]  write_reg_rd,
    output logic [31:0] reg_write_data,
    output logic        reg_write_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;
    localparam logic [2:0] LT_LWL = 3'd5;
    localparam logic [2:0] LT_LWR = 3'd6;

    typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  addr_lo, addr_lo_nxt;
    logic [2:0]  type_q, type_nxt;
    logic [31:0] rt_old_q, rt_old_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0] mem_address_nxt, reg_write_data_nxt;
    logic [4:0]  write_reg_rd_nxt;
    logic        mem_read_nxt, reg_write_enable_nxt, busy_nxt, done_nxt, error_nxt;

    logic        bad_req;
    logic [31:0] ext;
    logic [5:0]  sh_lo, sh_wl, sh_mask_l;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign mem_byteenable = 4'b1111;

    always_comb begin
        bad_req = 1'b0;
        case (load_type)
            LT_LW:          bad_req = (addr[1:0] != 2'b00);
            LT_LH, LT_LHU:  bad_req = addr[0];
            3'd7:           bad_req = 1'b1;
            default:        bad_req = 1'b0;
        endcase
    end

    // Extraction works on the live read data; it is only used on the
    // cycle where mem_waitrequest is low, which is when that data is valid.
    always_comb begin
        sh_lo     = {1'b0, addr_lo, 3'b000};
        sh_wl     = {1'b0, 2'd3 - addr_lo, 3'b000};
        sh_mask_l = ({4'b0000, addr_lo} + 6'd1) << 3;
        byte_sel  = 8'(mem_readdata >> sh_lo);
        half_sel  = addr_lo[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        ext       = mem_readdata;
        case (type_q)
            LT_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  ext = {24'h000000, byte_sel};
            LT_LH:   ext = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  ext = {16'h0000, half_sel};
            LT_LWL:  ext = (mem_readdata << sh_wl) | (rt_old_q & (32'hFFFFFFFF >> sh_mask_l));
            LT_LWR:  ext = (mem_readdata >> sh_lo) | (rt_old_q & ~(32'hFFFFFFFF >> sh_lo));
            default: ext = mem_readdata;
        endcase
    end

    always_comb begin
        state_nxt            = state;
        addr_lo_nxt          = addr_lo;
        type_nxt             = type_q;
        rt_old_nxt           = rt_old_q;
        cnt_nxt              = cnt;
        mem_address_nxt      = mem_address;
        mem_read_nxt         = mem_read;
        write_reg_rd_nxt     = write_reg_rd;
        reg_write_data_nxt   = reg_write_data;
        reg_write_enable_nxt = 1'b0;
        busy_nxt             = busy;
        done_nxt             = 1'b0;
        error_nxt            = 1'b0;
        case (state)
            // WRITE is the final cycle of a load, so a start seen there is
            // treated like one seen in IDLE; this gives back-to-back loads.
            IDLE, WRITE: begin
                state_nxt    = IDLE;
                busy_nxt     = 1'b0;
                mem_read_nxt = 1'b0;
                if (start) begin
                    addr_lo_nxt      = addr[1:0];
                    type_nxt         = load_type;
                    rt_old_nxt       = rt_old;
                    write_reg_rd_nxt = rt_index;
                    mem_address_nxt  = {addr[31:2], 2'b00};
                    busy_nxt         = 1'b1;
                    if (bad_req) begin
                        state_nxt = WRITE;
                        done_nxt  = 1'b1;
                        error_nxt = 1'b1;
                    end else begin
                        state_nxt    = REQ;
                        mem_read_nxt = 1'b1;
                        cnt_nxt      = CW'(TIMEOUT_CYCLES);
                    end
                end
            end
            REQ: begin
                if (!mem_waitrequest) begin
                    state_nxt            = WRITE;
                    mem_read_nxt         = 1'b0;
                    done_nxt             = 1'b1;
                    reg_write_data_nxt   = ext;
                    reg_write_enable_nxt = !(SUPPRESS_R0 && (write_reg_rd == 5'd0));
                end else if (cnt <= CW'(1)) begin
                    state_nxt    = WRITE;
                    mem_read_nxt = 1'b0;
                    done_nxt     = 1'b1;
                    error_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                busy_nxt     = 1'b0;
                mem_read_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            addr_lo          <= 2'b00;
            type_q           <= 3'd0;
            rt_old_q         <= 32'd0;
            cnt              <= '0;
            mem_address      <= 32'd0;
            mem_read         <= 1'b0;
            write_reg_rd     <= 5'd0;
            reg_write_data   <= 32'd0;
            reg_write_enable <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else if (clk_enable) begin
            state            <= state_nxt;
            addr_lo          <= addr_lo_nxt;
            type_q           <= type_nxt;
            rt_old_q         <= rt_old_nxt;
            cnt              <= cnt_nxt;
            mem_address      <= mem_address_nxt;
            mem_read         <= mem_read_nxt;
            write_reg_rd     <= write_reg_rd_nxt;
            reg_write_data   <= reg_write_data_nxt;
            reg_write_enable <= reg_write_enable_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            error            <= error_nxt;
        end
    end

endmodule
